// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
// Write-side pointer and full-flag generator for an asynchronous FIFO. All
// logic sits in the write clock domain.
//
// Keeps the binary write pointer and drives the RAM write address from it.
// Produces a registered Gray copy of the pointer that crosses to the read
// domain. Compares the next write pointer against the synchronized read
// pointer to register full, and generates the write-acknowledge and
// overflow pulses.
//
// Optional feature macro: FIFO_ALMOST_FULL_EN
//   defined   : almost_full is registered as (fill level >= AF_THRESH)
//   undefined : almost_full is tied to 0 and no level logic is built
//
// Parameters
//   DEPTH      address bits; FIFO holds 2**DEPTH entries (DEPTH >= 2)
//   AF_THRESH  almost-full threshold in entries, 1..2**DEPTH
//
// Ports
//   clk          in   1        write-domain clock, posedge
//   reset        in   1        synchronous active-high reset
//   wr_en        in   1        write request
//   rptr_sync    in   DEPTH+1  read pointer (Gray), already synchronized
//   wptr_gray    out  DEPTH+1  registered Gray write pointer
//   waddr        out  DEPTH    RAM write address
//   full         out  1        registered full flag
//   wr_ack       out  1        pulse one cycle after an accepted write
//   overflow     out  1        pulse one cycle after a write made while full
//   almost_full  out  1        registered almost-full flag (0 if disabled)
// ---------------------------------------------------------------------------
module fifo_wptr_full #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DEPTH:0]   rptr_sync,
  output logic [DEPTH:0]   wptr_gray,
  output logic [DEPTH-1:0] waddr,
  output logic             full,
  output logic             wr_ack,
  output logic             overflow,
  output logic             almost_full
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_wptr_full: DEPTH must be at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > (2 ** DEPTH)) begin : g_bad_thresh
    $error("fifo_wptr_full: AF_THRESH must be in 1..2**DEPTH");
  end

  logic [DEPTH:0] wbin;
  logic [DEPTH:0] wbin_next;
  logic [DEPTH:0] wgray_next;
  logic [DEPTH:0] rptr_full_cmp;
  logic           accept;
  logic           full_next;

  // Acceptance uses the registered full, so a write in the cycle the read
  // pointer moves is still refused; full is pessimistic, never optimistic.
  assign accept     = wr_en & ~full;
  assign wbin_next  = wbin + {{DEPTH{1'b0}}, accept};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // In Gray code, "write is exactly 2**DEPTH ahead of read" means the two
  // MSBs differ and all remaining bits match.
  assign rptr_full_cmp = {~rptr_sync[DEPTH:DEPTH-1], rptr_sync[DEPTH-2:0]};
  assign full_next     = (wgray_next == rptr_full_cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      wbin      <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      full      <= full_next;
      wr_ack    <= accept;
      overflow  <= wr_en & full;
    end
  end

  assign waddr = wbin[DEPTH-1:0];

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [DEPTH:0] AF_LEVEL = (DEPTH + 1)'(AF_THRESH);

  logic [DEPTH:0] rbin;
  logic [DEPTH:0] level_next;
  logic           af_next;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin        = '0;
    rbin[DEPTH] = rptr_sync[DEPTH];
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptr_sync[i];
    end
  end

  // Modulo subtraction gives the true fill level even across pointer wrap.
  assign level_next = wbin_next - rbin;
  assign af_next    = (level_next >= AF_LEVEL);

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= af_next;
    end
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;

  localparam int DEPTH = 2;

`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [DEPTH:0]   rptr_sync;
  logic [DEPTH:0]   wptr_gray;
  logic [DEPTH-1:0] waddr;
  logic             full;
  logic             wr_ack;
  logic             overflow;
  logic             almost_full;

  // {wptr_gray, waddr, full, wr_ack, overflow, almost_full}
  logic [8:0] obs;
  assign obs = {wptr_gray, waddr, full, wr_ack, overflow, almost_full};

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fifo_wptr_full #(
    .DEPTH     (DEPTH),
    .AF_THRESH (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .rptr_sync   (rptr_sync),
    .wptr_gray   (wptr_gray),
    .waddr       (waddr),
    .full        (full),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .almost_full (almost_full)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [8:0] exp;
    reset = 1'b1; wr_en = 1'b1; rptr_sync = 3'b000;
    tick; tick;
    exp = 9'b000_00_0_0_0_0;
    total_cnt++;
    if (obs !== exp) $display("FAIL reset: got %b expected %b", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_fill;
    logic [2:0] g [4];
    logic [8:0] exp;
    g = '{3'b001, 3'b011, 3'b010, 3'b110};
    reset = 1'b0; rptr_sync = 3'b000; wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      exp = {g[i], 2'(i + 1), (i == 3), 1'b1, 1'b0, AF_ON && (i >= 2)};
      total_cnt++;
      if (obs !== exp) $display("FAIL fill[%0d]: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow;
    logic [8:0] exp;
    wr_en = 1'b1;
    tick;
    exp = {3'b110, 2'b00, 1'b1, 1'b0, 1'b1, AF_ON};
    total_cnt++;
    if (obs !== exp) $display("FAIL overflow_pulse: got %b expected %b", obs, exp);
    else pass_cnt++;
    wr_en = 1'b0;
    tick;
    exp = {3'b110, 2'b00, 1'b1, 1'b0, 1'b0, AF_ON};
    total_cnt++;
    if (obs !== exp) $display("FAIL overflow_end: got %b expected %b", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_drain_release;
    logic [8:0] exp;
    rptr_sync = 3'b001; wr_en = 1'b0;
    tick;
    exp = {3'b110, 2'b00, 1'b0, 1'b0, 1'b0, AF_ON};
    total_cnt++;
    if (obs !== exp) $display("FAIL drain_release: got %b expected %b", obs, exp);
    else pass_cnt++;
    wr_en = 1'b1;
    tick;
    exp = {3'b111, 2'b01, 1'b1, 1'b1, 1'b0, AF_ON};
    total_cnt++;
    if (obs !== exp) $display("FAIL refill: got %b expected %b", obs, exp);
    else pass_cnt++;
    wr_en = 1'b0;
    tick;
    exp = {3'b111, 2'b01, 1'b1, 1'b0, 1'b0, AF_ON};
    total_cnt++;
    if (obs !== exp) $display("FAIL refill_hold: got %b expected %b", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [2:0] g [8];
    logic [8:0] exp;
    g = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    reset = 1'b1; wr_en = 1'b0; rptr_sync = 3'b000;
    tick;
    reset = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rptr_sync = (i == 0) ? 3'b000 : g[i-1];
      tick;
      exp = {g[i], 2'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0};
      total_cnt++;
      if (obs !== exp) $display("FAIL wrap[%0d]: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_midop_reset;
    logic [8:0] exp;
    reset = 1'b1; wr_en = 1'b0; rptr_sync = 3'b000;
    tick;
    reset = 1'b0; wr_en = 1'b1;
    tick; tick;
    exp = {3'b011, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL midop_two_writes: got %b expected %b", obs, exp);
    else pass_cnt++;
    reset = 1'b1;
    tick;
    exp = 9'b000_00_0_0_0_0;
    total_cnt++;
    if (obs !== exp) $display("FAIL midop_reset: got %b expected %b", obs, exp);
    else pass_cnt++;
    reset = 1'b0; wr_en = 1'b0;
    tick;
    total_cnt++;
    if (obs !== exp) $display("FAIL midop_after_reset: got %b expected %b", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_almost_full;
    logic [8:0] exp;
    reset = 1'b1; wr_en = 1'b0; rptr_sync = 3'b000;
    tick;
    reset = 1'b0; wr_en = 1'b1;
    tick; tick;
    exp = {3'b011, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL af_two: got %b expected %b", obs, exp);
    else pass_cnt++;
    tick;
    exp = {3'b010, 2'b11, 1'b0, 1'b1, 1'b0, AF_ON};
    total_cnt++;
    if (obs !== exp) $display("FAIL af_three: got %b expected %b", obs, exp);
    else pass_cnt++;
    wr_en = 1'b0; rptr_sync = 3'b001;
    tick;
    exp = {3'b010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL af_drop: got %b expected %b", obs, exp);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rptr_sync = '0;
    test_reset;
    test_fill;
    test_overflow;
    test_drain_release;
    test_wrap;
    test_midop_reset;
    test_almost_full;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
